// File: rtl/fp16_product_normalizer.sv
// Normalizes, RNE-rounds and packs the raw int8 x fp16 multiplier fields into an fp16 result.
// Three-stage elastic pipeline: leading-one detect, align/denormalize, round/pack.
module fp16_product_normalizer #(
  parameter int MAN_W       = 19,
  parameter int EXP_W       = 5,
  parameter int PIPE_STAGES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign_in,
  input  logic [EXP_W-1:0] exp_in,
  input  logic [MAN_W-1:0] man_in,
  input  logic             act_is_nan,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_fp16,
  output logic             out_ovf
);

  if (PIPE_STAGES != 3) begin : g_bad_stages
    $error("fp16_product_normalizer supports only PIPE_STAGES = 3");
  end

  localparam int EXT_W = MAN_W + 13;

  typedef enum logic [1:0] {K_NUM, K_ZERO, K_INF, K_NAN} kind_t;

  // Stage 1 registers
  logic             s1_valid, s1_sign;
  logic [EXP_W-1:0] s1_exp;
  logic [MAN_W-1:0] s1_man;
  logic [4:0]       s1_pos;
  kind_t            s1_kind;
  // Stage 2 registers
  logic             s2_valid, s2_sign, s2_g, s2_st;
  logic [6:0]       s2_exp;
  logic [10:0]      s2_man;
  kind_t            s2_kind;

  logic s1_free, s2_free, s3_free;

  assign s3_free  = ~out_valid | out_ready;
  assign s2_free  = ~s2_valid | s3_free;
  assign s1_free  = ~s1_valid | s2_free;
  assign in_ready = s1_free;

  // Stage 1 combinational: leading-one position and special classification
  logic [4:0] lead_pos;
  kind_t      kind_in;

  always_comb begin
    lead_pos = '0;
    for (int unsigned i = 0; i < MAN_W; i++)
      if (man_in[i]) lead_pos = 5'(i);
    if (act_is_nan)            kind_in = K_NAN;
    else if (exp_in == '1)     kind_in = (man_in == '0) ? K_NAN : K_INF;
    else if (man_in == '0)     kind_in = K_ZERO;
    else                       kind_in = K_NUM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_man   <= '0;
      s1_pos   <= '0;
      s1_kind  <= K_ZERO;
    end else if (s1_free) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= sign_in;
        s1_exp  <= exp_in;
        s1_man  <= man_in;
        s1_pos  <= lead_pos;
        s1_kind <= kind_in;
      end
    end
  end

  // Stage 2 combinational: the normalize shift and the subnormal right shift
  // collapse into one right shift of man<<11 by (p + sub); bit 0 is guard.
  logic [EXP_W-1:0]  e_eff;
  logic signed [6:0] e_raw, sub_dist;
  logic [5:0]        sub_amt, sh;
  logic [EXT_W-1:0]  ext, mask;
  logic [11:0]       q_lo;
  logic              sticky;
  logic [6:0]        e_norm;

  always_comb begin
    e_eff    = (s1_exp == '0) ? EXP_W'(1) : s1_exp;
    e_raw    = $signed({2'b00, s1_pos}) + $signed({2'b00, e_eff}) - 7'sd10;
    sub_dist = 7'sd1 - e_raw;
    sub_amt  = '0;
    if (e_raw <= 7'sd0)
      sub_amt = (sub_dist > 7'sd12) ? 6'd12 : sub_dist[5:0];
    sh       = {1'b0, s1_pos} + sub_amt;
    ext      = {2'b00, s1_man, 11'b0};
    q_lo     = 12'(ext >> sh);
    mask     = (EXT_W'(1) << sh) - EXT_W'(1);
    sticky   = |(ext & mask);
    e_norm   = (e_raw <= 7'sd0) ? '0 : e_raw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_g     <= 1'b0;
      s2_st    <= 1'b0;
      s2_exp   <= '0;
      s2_man   <= '0;
      s2_kind  <= K_ZERO;
    end else if (s2_free) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign <= s1_sign;
        s2_g    <= q_lo[0];
        s2_st   <= sticky;
        s2_exp  <= e_norm;
        s2_man  <= q_lo[11:1];
        s2_kind <= s1_kind;
      end
    end
  end

  // Stage 3 combinational: RNE round, carry/subnormal promotion, pack
  logic        inc, pk_ovf;
  logic [11:0] man_rnd;
  logic [6:0]  exp_rnd;
  logic [15:0] pk_fp16;

  always_comb begin
    inc     = s2_g & (s2_st | s2_man[0]);
    man_rnd = {1'b0, s2_man} + {11'b0, inc};
    exp_rnd = s2_exp + {6'b0, man_rnd[11]} + {6'b0, (s2_exp == '0) & man_rnd[10]};
    pk_fp16 = {s2_sign, exp_rnd[4:0], man_rnd[9:0]};
    pk_ovf  = 1'b0;
    if (exp_rnd >= 7'd31) begin
      pk_fp16 = {s2_sign, 15'h7C00};
      pk_ovf  = 1'b1;
    end
    unique case (s2_kind)
      K_NAN:   begin pk_fp16 = 16'h7E00;              pk_ovf = 1'b0; end
      K_INF:   begin pk_fp16 = {s2_sign, 15'h7C00};   pk_ovf = 1'b0; end
      K_ZERO:  begin pk_fp16 = {s2_sign, 15'h0000};   pk_ovf = 1'b0; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_fp16  <= '0;
      out_ovf   <= 1'b0;
    end else if (s3_free) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_fp16 <= pk_fp16;
        out_ovf  <= pk_ovf;
      end
    end
  end

endmodule

// File: tb/tb_fp16_product_normalizer.sv
// Scoreboard bench for fp16_product_normalizer: expected {ovf,fp16} pushed on input
// transfer, popped and compared on output transfer.
module tb_fp16_product_normalizer;

  logic        clk, rst_n;
  logic        in_valid, in_ready, sign_in, act_is_nan;
  logic [4:0]  exp_in;
  logic [18:0] man_in;
  logic        out_valid, out_ready, out_ovf;
  logic [15:0] out_fp16;

  fp16_product_normalizer #(.MAN_W(19), .EXP_W(5), .PIPE_STAGES(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .sign_in(sign_in), .exp_in(exp_in), .man_in(man_in), .act_is_nan(act_is_nan),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_fp16(out_fp16), .out_ovf(out_ovf)
  );

  typedef struct { logic [16:0] v; int cyc; } ent_t;
  typedef struct { logic s; logic [4:0] e; logic [18:0] m; logic nan; logic [16:0] want; } vec_t;

  ent_t        sb[$];
  int          n_checks = 0, n_pass = 0;
  int          cyc = 0;
  int          mode = 0;
  bit          check_lat = 0;
  bit          stalled = 0;
  logic [16:0] held;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, want);
  endtask

  // Independent reference: iterative normalize in ulp units, then RNE.
  function automatic logic [16:0] model(input logic s, input logic [4:0] ex, input int m0, input logic nan);
    int m, u, g, st, b;
    if (nan) return {1'b0, 16'h7E00};
    if (ex == 5'd31) return (m0 == 0) ? {1'b0, 16'h7E00} : {1'b0, s, 15'h7C00};
    if (m0 == 0) return {1'b0, s, 15'h0000};
    m = m0; u = ((ex == 0) ? 1 : int'(ex)) - 25; g = 0; st = 0;
    while (m >= 2048) begin st = st | g; g = m & 1; m = m >> 1; u++; end
    while (m < 1024 && u > -24) begin m = m << 1; u--; end
    if (g != 0 && (st != 0 || (m & 1) != 0)) m++;
    if (m == 2048) begin m = 1024; u++; end
    if (m < 1024) return {1'b0, s, 5'd0, 10'(m)};
    b = u + 25;
    if (b >= 31) return {1'b1, s, 15'h7C00};
    return {1'b0, s, 5'(b), 10'(m & 1023)};
  endfunction

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    int ph = 0;
    out_ready = 1;
    forever begin
      @(negedge clk);
      case (mode)
        0: out_ready = 1;
        1: begin out_ready = (ph % 4 == 0) || (ph % 4 == 3); ph++; end
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 0;
      endcase
    end
  end

  // Output monitor, sampled 2 time units after the falling edge
  initial begin
    ent_t e;
    forever begin
      @(negedge clk); #2;
      if (!rst_n) stalled = 0;
      else begin
        if (stalled) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_data", 32'({out_ovf, out_fp16}), 32'(held));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) check("spurious_out", 32'(out_valid), 32'd0);
          else begin
            e = sb.pop_front();
            check("result", 32'({out_ovf, out_fp16}), 32'(e.v));
            if (check_lat) check("latency", 32'(cyc - e.cyc), 32'd3);
          end
        end
        stalled = out_valid && !out_ready;
        held    = {out_ovf, out_fp16};
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send(input logic s, input logic [4:0] e, input logic [18:0] m,
                      input logic nan, input logic [16:0] want);
    bit go, done;
    done = 0;
    in_valid = 1; sign_in = s; exp_in = e; man_in = m; act_is_nan = nan;
    for (int k = 0; k < 200 && !done; k++) begin
      #3; go = in_ready;
      if (go) sb.push_back('{want, cyc});
      @(negedge clk);
      done = go;
    end
    if (!done) check("send_timeout", 32'(done), 32'd1);
    in_valid = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && sb.size() != 0; k++) @(negedge clk);
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic send_rand();
    logic s; logic [4:0] e; logic [18:0] m;
    s = 1'($urandom_range(0, 1));
    e = 5'($urandom_range(0, 31));
    m = 19'($urandom_range(0, 262016));
    if ($urandom_range(0, 7) == 0) m = '0;
    send(s, e, m, 1'b0, model(s, e, int'(m), 1'b0));
  endtask

  vec_t dv[16];

  initial begin
    dv = '{
      '{1'b0, 5'd15, 19'd2048,   1'b0, 17'h0_4000},
      '{1'b1, 5'd15, 19'd4608,   1'b0, 17'h0_C480},
      '{1'b0, 5'd15, 19'd3075,   1'b0, 17'h0_4202},
      '{1'b0, 5'd15, 19'd4097,   1'b0, 17'h0_4400},
      '{1'b0, 5'd30, 19'd259969, 1'b0, 17'h1_7C00},
      '{1'b0, 5'd31, 19'd0,      1'b0, 17'h0_7E00},
      '{1'b0, 5'd10, 19'd5,      1'b1, 17'h0_7E00},
      '{1'b1, 5'd10, 19'd0,      1'b0, 17'h0_8000},
      '{1'b0, 5'd0,  19'd1,      1'b0, 17'h0_0001},
      '{1'b0, 5'd0,  19'd3,      1'b0, 17'h0_0003},
      '{1'b0, 5'd1,  19'd1023,   1'b0, 17'h0_03FF},
      '{1'b0, 5'd0,  19'd2047,   1'b0, 17'h0_07FF},
      '{1'b0, 5'd15, 19'd4095,   1'b0, 17'h0_4400},
      '{1'b0, 5'd29, 19'd4095,   1'b0, 17'h1_7C00},
      '{1'b1, 5'd31, 19'd7,      1'b0, 17'h0_FC00},
      '{1'b0, 5'd15, 19'd1024,   1'b0, 17'h0_3C00}
    };
    rst_n = 0; in_valid = 0; sign_in = 0; exp_in = '0; man_in = '0; act_is_nan = 0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_fp16", 32'(out_fp16), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1;
    @(negedge clk);

    check_lat = 1; mode = 0;
    foreach (dv[i]) send(dv[i].s, dv[i].e, dv[i].m, dv[i].nan, dv[i].want);
    drain();
    check_lat = 0;

    mode = 1;
    repeat (8) send_rand();
    drain();

    mode = 2;
    repeat (40) send_rand();
    drain();

    // Reset with entries in flight
    mode = 3;
    @(negedge clk);
    send(1'b0, 5'd15, 19'd2048, 1'b0, 17'h0_4000);
    send(1'b1, 5'd15, 19'd4608, 1'b0, 17'h0_C480);
    repeat (2) @(negedge clk);
    #1 rst_n = 0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1; mode = 0;
    repeat (12) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fp16_product_normalizer.md
Name: fp16_product_normalizer

Overview:
- Consumes the raw fields from the int8×fp16 multiplier: sign, activation biased exponent, and 19-bit unnormalized integer significand product.
- Normalizes, rounds (RNE) and packs them into an IEEE fp16 result.
- Sits directly downstream of the multiplier and feeds the FMA accumulate stage.
- 3-stage elastic pipeline with valid/ready handshake at both ends.

Parameters:
- MAN_W, 19, width of incoming integer significand product.
- EXP_W, 5, width of incoming exponent field (fp16 biased).
- PIPE_STAGES, 3, fixed. Documentation only; other values unsupported.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input fields valid
- in_ready  out  1  block accepts input this cycle
- sign_in  in  1  product sign (int8 sign XOR act sign)
- exp_in  in  5  activation biased exponent field (0..31), unmodified
- man_in  in  19  |int8| × {hidden,act_man}; legal range 0..262016
- act_is_nan  in  1  activation was NaN (exp 31, man≠0)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_fp16  out  16  packed fp16 result
- out_ovf  out  1  result saturated to ±inf by overflow (not input inf)

Behaviour:
- Reset (async assert, sync deassert by user): all stage valids 0, out_valid=0, out_fp16=16'h0000, out_ovf=0, in_ready=1.
- Handshake: transfer on valid&ready at each end. Stage k advances when stage k+1 is empty or advancing. in_ready = ~s1_valid | s1_advance.
- out_fp16 and out_valid are held stable while out_valid & ~out_ready.
- Latency 3 cycles, input accept to out_valid, with no backpressure. Throughput 1/cycle. No bubbles inserted when out_ready is held high.
- Value semantics: e = (exp_in==0) ? 1 : exp_in. Value = (-1)^sign_in × man_in × 2^(e-25).
- S1: register fields. Compute leading-one position p (0..18) of man_in and zero flag.
- S2:
  - E = p + e − 10, signed 7-bit.
  - If p>10: right shift by p−10, capturing guard bit and sticky (OR of lower bits).
  - If p≤10: left shift by 10−p (exact).
  - If E≤0: additional right shift by min(1−E, 12) with guard/sticky accumulated; E forced to 0.
- S3:
  - Round to nearest even: increment if guard & (sticky | lsb).
  - Carry out of 11-bit significand: E+1, significand 1024.
  - Subnormal rounding up to 1024 yields E=1 through the normal packing.
  - If E≥31 after rounding: ±inf (0x7C00 | sign<<15), out_ovf=1.
- Specials, in priority order:
  - act_is_nan: 0x7E00.
  - exp_in==31 and man_in==0 (inf×0): 0x7E00.
  - exp_in==31 otherwise: ±inf with out_ovf=0.
  - man_in==0: signed zero (sign_in<<15).
- Underflow to zero after shifting/rounding yields signed zero.
- man_in > 262016 is illegal. Output is undefined but the handshake must remain correct.
- Reset mid-operation: all in-flight entries are discarded. No output appears for them after reset release.

Test Plan:
- Basic: sign 0, exp 15, man 2048 (int8=2 × 1.0) -> out_fp16=0x4000 exactly 3 cycles later, out_ovf=0.
- Sign/fraction: sign 1, exp 15, man 4608 (−3 × 1.5) -> 0xC480.
- RNE tie: sign 0, exp 15, man 3075 (3 × 0x3C01) -> 0x4202 (tie rounded to even). Also man 4097 -> 0x4400 (rounded down).
- Overflow/specials:
  - exp 30, man 259969 (127 × 65504) -> 0x7C00, out_ovf=1.
  - exp 31, man 0 -> 0x7E00.
  - act_is_nan=1 -> 0x7E00.
  - sign 1, man 0, exp 10 -> 0x8000.
- Subnormal: exp 0, man 1 -> 0x0001. exp 0, man 3 -> 0x0003. exp 1, man 2047×... such that E=0 -> correct subnormal with RNE.
- Backpressure/reset:
  - Stream 8 back-to-back inputs with out_ready toggling 1,0,0,1… -> all 8 results in order, none dropped or duplicated, held stable while stalled.
  - Deassert rst_n with 2 entries in flight -> out_valid=0 immediately and no stale results after release.
